// File: rtl/l1_fill_responder.sv
`timescale 1ns/1ps
// l1_fill_responder
//   MMU-side responder for L1 instruction-cache line fills.
//   A cacheable request fetches a 32-byte line as 8 sequential word beats
//   and returns it as a 256-bit line. An MMIO request performs one word read,
//   which is returned in bits [31:0].
//
//   Optional feature (macro LAST_LINE_BUF_EN): remembers the tag of the last
//   completed cacheable fill. A repeat request for that line is answered from
//   the held line data without touching memory. sync invalidates the tag.
//   When the macro is not defined, sync is ignored.
//
// Ports
//   sys_clk           clock; all state updates on posedge
//   rst               asynchronous active-high reset
//   l1_mmu_req_read   level read request from L1
//   l1_mmu_req_addr   request address ([4:0] ignored for cacheable)
//   mmu_l1_done       one-cycle pulse, mmu_l1_read_data valid
//   mmu_l1_read_data  line data, word i at [32i+31:32i]; MMIO word at [31:0]
//   sync              invalidate last-line tag
//   mem_req           memory word request, held until mem_ack
//   mem_addr          word address of the current beat
//   mem_ack           mem_rdata valid, beat complete
//   mem_rdata         memory read data
module l1_fill_responder #(
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         l1_mmu_req_read,
  input  logic [31:0]  l1_mmu_req_addr,
  output logic         mmu_l1_done,
  output logic [255:0] mmu_l1_read_data,
  input  logic         sync,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MMIO,
    S_DONE,
    S_COOL
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [31:0]    addr_q;
  logic [2:0]     beat;
  logic [255:0]   line_data;
  logic           req_is_mmio;
  logic           buf_hit;
  logic           last_beat_ack;

  assign req_is_mmio   = (l1_mmu_req_addr & MMIO_MASK) == MMIO_BASE;
  assign last_beat_ack = (state == S_FILL) && mem_ack && (beat == 3'd7);

`ifdef LAST_LINE_BUF_EN
  logic        tag_valid;
  logic [26:0] tag_line;
  logic        unused_ok;

  assign buf_hit   = tag_valid && !req_is_mmio && (tag_line == l1_mmu_req_addr[31:5]);
  assign unused_ok = ^addr_q[1:0];

  // sync takes priority over a fill completing in the same cycle so an
  // invalidate can never be lost.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_line  <= '0;
    end else if (sync) begin
      tag_valid <= 1'b0;
    end else if (last_beat_ack) begin
      tag_valid <= 1'b1;
      tag_line  <= addr_q[31:5];
    end
  end
`else
  logic unused_ok;

  assign buf_hit   = 1'b0;
  assign unused_ok = ^{sync, addr_q[1:0]};
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    mmu_l1_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (l1_mmu_req_read) begin
          if (req_is_mmio)  state_nxt = S_MMIO;
          else if (buf_hit) state_nxt = S_DONE;
          else              state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:5], beat, 2'b00};
        if (last_beat_ack) state_nxt = S_DONE;
      end
      S_MMIO: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        if (mem_ack) state_nxt = S_DONE;
      end
      S_DONE: begin
        mmu_l1_done = 1'b1;
        state_nxt   = S_COOL;
      end
      // L1 registers its request, so it is still high for one cycle after
      // done; this state swallows that stale cycle.
      S_COOL: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The address is captured once in IDLE; later changes on the L1 address
  // bus are ignored until the next accepted request.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      beat      <= '0;
      line_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (l1_mmu_req_read) begin
            addr_q <= l1_mmu_req_addr;
            beat   <= '0;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            line_data[{beat, 5'b00000} +: 32] <= mem_rdata;
            if (beat != 3'd7) beat <= beat + 3'd1;
          end
        end
        S_MMIO: begin
          if (mem_ack) line_data <= {224'b0, mem_rdata};
        end
        default: begin
        end
      endcase
    end
  end

  assign mmu_l1_read_data = line_data;

endmodule

// File: tb/tb_l1_fill_responder.sv
`timescale 1ns/1ps
module tb_l1_fill_responder;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         req;
  logic [31:0]  req_addr;
  logic         done;
  logic [255:0] line;
  logic         sync;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  l1_fill_responder dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .l1_mmu_req_read  (req),
    .l1_mmu_req_addr  (req_addr),
    .mmu_l1_done      (done),
    .mmu_l1_read_data (line),
    .sync             (sync),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  // Memory model: acks after cur_gap idle cycles, word = base + step*k
  int          fixed_gap  = 0;
  bit          rand_gaps  = 1'b0;
  logic [31:0] rdata_base = '0;
  logic [31:0] rdata_step = '0;
  int          wait_cnt   = 0;
  int          cur_gap    = 0;
  bit          have_prev  = 1'b0;
  bit          prev_acked = 1'b0;
  logic [31:0] prev_addr  = '0;
  int          stab_viol  = 0;
  int          done_cnt   = 0;
  bit          mem_req_seen = 1'b0;
  logic [31:0] beat_log[$];

  always @(negedge sys_clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_req === 1'b1) begin
      mem_req_seen = 1'b1;
      if (have_prev && !prev_acked && mem_addr !== prev_addr) stab_viol++;
      if (wait_cnt >= cur_gap) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_base + rdata_step * {29'b0, mem_addr[4:2]};
        beat_log.push_back(mem_addr);
        wait_cnt   = 0;
        cur_gap    = rand_gaps ? int'($urandom_range(0, 5)) : fixed_gap;
        prev_acked = 1'b1;
      end else begin
        mem_ack    = 1'b0;
        wait_cnt++;
        prev_acked = 1'b0;
      end
      prev_addr = mem_addr;
      have_prev = 1'b1;
    end else begin
      mem_ack   = 1'b0;
      wait_cnt  = 0;
      have_prev = 1'b0;
    end
  end

  // Waits (bounded) until done is seen at a negedge; cyc counts negedges.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge sys_clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 200);
  endtask

  task automatic setup_mem(input int gap, input logic [31:0] base, input logic [31:0] step);
    fixed_gap  = gap;
    cur_gap    = gap;
    rand_gaps  = 1'b0;
    rdata_base = base;
    rdata_step = step;
    stab_viol  = 0;
    beat_log.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || line !== 256'h0) begin
      errors++;
      $display("FAIL reset: done=%b mem_req=%b mem_addr=%h line=%h required all zero",
               done, mem_req, mem_addr, line);
    end
    rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_fill;
    int cyc;
    int d0;
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[32*k +: 32] = 32'hA000_0000 + k;
    setup_mem(0, 32'hA000_0000, 32'h1);
    d0 = done_cnt;
    req = 1'b1;
    req_addr = 32'h0000_1234;
    wait_done(cyc);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL fill_latency: got %0d required 9", cyc);
    end
    checks++;
    if (line[255:224] !== 32'hA000_0007) begin
      errors++;
      $display("FAIL fill_top_word: got %h required a0000007", line[255:224]);
    end
    checks++;
    if (line !== exp) begin
      errors++;
      $display("FAIL fill_line: got %h required %h", line, exp);
    end
    @(negedge sys_clk);
    req = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL fill_done_count: got %0d required 1", done_cnt - d0);
    end
    checks++;
    if (beat_log.size() !== 8) begin
      errors++;
      $display("FAIL fill_beat_count: got %0d required 8", beat_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (beat_log[k] !== 32'h0000_1220 + 4 * k) begin
          errors++;
          $display("FAIL fill_addr%0d: got %h required %h", k, beat_log[k], 32'h0000_1220 + 4 * k);
        end
      end
    end
    checks++;
    if (line !== exp) begin
      errors++;
      $display("FAIL fill_hold: got %h required %h", line, exp);
    end
  endtask

  task automatic test_mmio;
    int cyc;
    int d0;
    setup_mem(3, 32'hDEAD_BEEF, 32'h0);
    d0 = done_cnt;
    req = 1'b1;
    req_addr = 32'hFFFF_0004;
    wait_done(cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL mmio_latency: got %0d required 5", cyc);
    end
    checks++;
    if (line !== {224'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL mmio_data: got %h required deadbeef in low word only", line);
    end
    @(negedge sys_clk);
    req = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (beat_log.size() !== 1 || beat_log[0] !== 32'hFFFF_0004) begin
      errors++;
      $display("FAIL mmio_beats: got %0d beats first %h required 1 beat at ffff0004",
               beat_log.size(), (beat_log.size() > 0) ? beat_log[0] : 32'h0);
    end
    checks++;
    if (done_cnt - d0 !== 1 || stab_viol !== 0) begin
      errors++;
      $display("FAIL mmio_done_stable: got done=%0d viol=%0d required 1 and 0", done_cnt - d0, stab_viol);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int d0;
    setup_mem(0, 32'h3300_0000, 32'h1);
    sync = 1'b1;
    d0 = done_cnt;
    req = 1'b1;
    req_addr = 32'h0000_3000;
    wait_done(cyc);
    @(negedge sys_clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cool_req: got %b required 0", mem_req);
    end
    @(negedge sys_clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_req: got %b required 0", mem_req);
    end
    @(negedge sys_clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL b2b_refill_start: got req=%b addr=%h required 1 00003000", mem_req, mem_addr);
    end
    req = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL b2b_refill_latency: got %0d required 8", cyc);
    end
    repeat (4) @(negedge sys_clk);
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0);
    end
    sync = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    int cyc;
    int d0;
    setup_mem(0, 32'h4400_0000, 32'h1);
    req = 1'b1;
    req_addr = 32'h0000_5000;
    repeat (5) @(negedge sys_clk);
    checks++;
    if (mem_addr !== 32'h0000_5010) begin
      errors++;
      $display("FAIL rst_beat4_addr: got %h required 00005010", mem_addr);
    end
    rst = 1'b1;
    req = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || line !== 256'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: done=%b mem_req=%b mem_addr=%h line=%h required all zero",
               done, mem_req, mem_addr, line);
    end
    d0 = done_cnt;
    mem_req_seen = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (12) @(negedge sys_clk);
    checks++;
    if (done_cnt - d0 !== 0 || mem_req_seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got done=%0d mem_req_seen=%b required 0 0", done_cnt - d0, mem_req_seen);
    end
    beat_log.delete();
    req = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL rst_refill_latency: got %0d required 9", cyc);
    end
    @(negedge sys_clk);
    req = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (beat_log.size() !== 8 || beat_log[0] !== 32'h0000_5000) begin
      errors++;
      $display("FAIL rst_refill_beat0: got %0d beats first %h required 8 from 00005000",
               beat_log.size(), (beat_log.size() > 0) ? beat_log[0] : 32'h0);
    end
  endtask

  task automatic test_last_line_buf;
    int cyc;
    logic [255:0] held;
`ifdef LAST_LINE_BUF_EN
    localparam int  EXP_HIT_CYC  = 1;
    localparam bit  EXP_HIT_SEEN = 1'b0;
`else
    localparam int  EXP_HIT_CYC  = 9;
    localparam bit  EXP_HIT_SEEN = 1'b1;
`endif
    setup_mem(0, 32'h6600_0000, 32'h1);
    req = 1'b1;
    req_addr = 32'h0000_1000;
    wait_done(cyc);
    @(negedge sys_clk);
    req = 1'b0;
    @(negedge sys_clk);
    held = line;
    mem_req_seen = 1'b0;
    req = 1'b1;
    req_addr = 32'h0000_1010;
    wait_done(cyc);
    checks++;
    if (cyc !== EXP_HIT_CYC || mem_req_seen !== EXP_HIT_SEEN) begin
      errors++;
      $display("FAIL llb_rerequest: got cyc=%0d mem_req_seen=%b required %0d %b",
               cyc, mem_req_seen, EXP_HIT_CYC, EXP_HIT_SEEN);
    end
    checks++;
    if (line !== held) begin
      errors++;
      $display("FAIL llb_data: got %h required %h", line, held);
    end
    @(negedge sys_clk);
    req = 1'b0;
    @(negedge sys_clk);
    sync = 1'b1;
    @(negedge sys_clk);
    sync = 1'b0;
    req = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL llb_after_sync: got %0d required 9", cyc);
    end
    @(negedge sys_clk);
    req = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_random_gaps;
    int cyc;
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[32*k +: 32] = 32'h7700_0000 + 32'h1111 * k;
    setup_mem(0, 32'h7700_0000, 32'h1111);
    rand_gaps = 1'b1;
    cur_gap = int'($urandom_range(0, 5));
    req = 1'b1;
    req_addr = 32'h0000_446C;
    wait_done(cyc);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rand_done: got %b required 1 within 200 cycles", done);
    end
    checks++;
    if (line !== exp) begin
      errors++;
      $display("FAIL rand_line: got %h required %h", line, exp);
    end
    checks++;
    if (stab_viol !== 0) begin
      errors++;
      $display("FAIL rand_stable: got %0d address changes while unacked required 0", stab_viol);
    end
    checks++;
    if (beat_log.size() !== 8 || beat_log[7] !== 32'h0000_447C) begin
      errors++;
      $display("FAIL rand_beats: got %0d beats last %h required 8 ending 0000447c",
               beat_log.size(), (beat_log.size() > 0) ? beat_log[beat_log.size()-1] : 32'h0);
    end
    @(negedge sys_clk);
    req = 1'b0;
    rand_gaps = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    req = 1'b0;
    req_addr = '0;
    sync = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    rst = 1'b1;
    test_reset();
    test_fill();
    test_mmio();
    test_back_to_back();
    test_reset_mid_fill();
    test_last_line_buf();
    test_random_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
